// File: rtl/cache_control.sv
// Controller for a direct-mapped write-back cache: sequences hits, dirty
// writebacks and line fills, and keeps saturating hit/miss/writeback counters.
module cache_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    input  logic             hit,
    input  logic             valid_out,
    input  logic             dirty_out,
    input  logic             pmem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic             dirty_load,
    output logic             dirty_in,
    output logic             valid_load,
    output logic             tag_load,
    output logic             data_load,
    output logic             data_in_sel,
    output logic             pmem_addr_sel,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state;
    state_t next_state;
    logic   hit_inc;
    logic   miss_inc;
    logic   wb_inc;
    logic   request;

    assign request = mem_read | mem_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        dirty_load    = 1'b0;
        dirty_in      = 1'b0;
        valid_load    = 1'b0;
        tag_load      = 1'b0;
        data_load     = 1'b0;
        data_in_sel   = 1'b0;
        pmem_addr_sel = 1'b0;
        hit_inc       = 1'b0;
        miss_inc      = 1'b0;
        wb_inc        = 1'b0;

        case (state)
            IDLE: begin
                if (request) begin
                    next_state = COMPARE;
                end
            end
            COMPARE: begin
                if (!request) begin
                    next_state = IDLE;
                end else if (hit) begin
                    mem_resp   = 1'b1;
                    hit_inc    = 1'b1;
                    next_state = IDLE;
                    // A simultaneous read+write is treated as a write.
                    if (mem_write) begin
                        data_load   = 1'b1;
                        data_in_sel = 1'b0;
                        dirty_load  = 1'b1;
                        dirty_in    = 1'b1;
                    end
                end else begin
                    miss_inc   = 1'b1;
                    next_state = (valid_out && dirty_out) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                if (pmem_resp) begin
                    dirty_load = 1'b1;
                    dirty_in   = 1'b0;
                    wb_inc     = 1'b1;
                    next_state = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read     = 1'b1;
                pmem_addr_sel = 1'b0;
                if (pmem_resp) begin
                    data_load   = 1'b1;
                    data_in_sel = 1'b1;
                    tag_load    = 1'b1;
                    valid_load  = 1'b1;
                    dirty_load  = 1'b1;
                    dirty_in    = 1'b0;
                    next_state  = COMPARE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Counters hold at all-ones instead of wrapping; reset beats any increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (hit_inc && hit_count != CNT_MAX) begin
                hit_count <= hit_count + CNT_ONE;
            end
            if (miss_inc && miss_count != CNT_MAX) begin
                miss_count <= miss_count + CNT_ONE;
            end
            if (wb_inc && wb_count != CNT_MAX) begin
                wb_count <= wb_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_cache_control.sv
// Table-driven bench for cache_control: per-cycle input/expected-output rows,
// checked against a default-width instance and a 2-bit-counter instance.
module tb_cache_control;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic        hit;
    logic        valid_out;
    logic        dirty_out;
    logic        pmem_resp;

    logic        mem_resp, pmem_read, pmem_write, dirty_load, dirty_in;
    logic        valid_load, tag_load, data_load, data_in_sel, pmem_addr_sel;
    logic [15:0] hit_count, miss_count, wb_count;

    logic        s_mem_resp, s_pmem_read, s_pmem_write, s_dirty_load, s_dirty_in;
    logic        s_valid_load, s_tag_load, s_data_load, s_data_in_sel, s_pmem_addr_sel;
    logic [1:0]  s_hit_count, s_miss_count, s_wb_count;

    int total;
    int bad;

    // Control vector order: {mem_resp, pmem_read, pmem_write, dirty_load, dirty_in,
    //                        valid_load, tag_load, data_load, data_in_sel, pmem_addr_sel}
    localparam logic [9:0] NONE = 10'b0000000000;
    localparam logic [9:0] RESP = 10'b1000000000;
    localparam logic [9:0] PRD  = 10'b0100000000;
    localparam logic [9:0] PWR  = 10'b0010000000;
    localparam logic [9:0] DLD  = 10'b0001000000;
    localparam logic [9:0] DIN  = 10'b0000100000;
    localparam logic [9:0] VLD  = 10'b0000010000;
    localparam logic [9:0] TLD  = 10'b0000001000;
    localparam logic [9:0] DTL  = 10'b0000000100;
    localparam logic [9:0] DSEL = 10'b0000000010;
    localparam logic [9:0] ASEL = 10'b0000000001;

    localparam logic [9:0] WHIT   = RESP | DTL | DLD | DIN;
    localparam logic [9:0] FILL   = PRD | DTL | DSEL | TLD | VLD | DLD;
    localparam logic [9:0] WBUSY  = PWR | ASEL;
    localparam logic [9:0] WBDONE = PWR | ASEL | DLD;

    typedef struct {
        logic       rst;
        logic       rd;
        logic       wr;
        logic       hit;
        logic       vld;
        logic       drt;
        logic       presp;
        logic [9:0] ctrl;
        int         hc;
        int         mc;
        int         wc;
    } vec_t;

    vec_t tbl[$];
    vec_t rst_seq[$];

    cache_control dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .hit(hit), .valid_out(valid_out), .dirty_out(dirty_out),
        .pmem_resp(pmem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .dirty_load(dirty_load), .dirty_in(dirty_in), .valid_load(valid_load),
        .tag_load(tag_load), .data_load(data_load), .data_in_sel(data_in_sel),
        .pmem_addr_sel(pmem_addr_sel),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    cache_control #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(s_mem_resp),
        .hit(hit), .valid_out(valid_out), .dirty_out(dirty_out),
        .pmem_resp(pmem_resp), .pmem_read(s_pmem_read), .pmem_write(s_pmem_write),
        .dirty_load(s_dirty_load), .dirty_in(s_dirty_in), .valid_load(s_valid_load),
        .tag_load(s_tag_load), .data_load(s_data_load), .data_in_sel(s_data_in_sel),
        .pmem_addr_sel(s_pmem_addr_sel),
        .hit_count(s_hit_count), .miss_count(s_miss_count), .wb_count(s_wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic rd, input logic wr,
                                input logic h, input logic v, input logic d,
                                input logic p, input logic [9:0] c,
                                input int hc, input int mc, input int wc);
        vec_t t;
        t.rst = r; t.rd = rd; t.wr = wr; t.hit = h; t.vld = v; t.drt = d;
        t.presp = p; t.ctrl = c; t.hc = hc; t.mc = mc; t.wc = wc;
        return t;
    endfunction

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    task automatic applyStimulus(input vec_t t);
        rst       = t.rst;
        mem_read  = t.rd;
        mem_write = t.wr;
        hit       = t.hit;
        valid_out = t.vld;
        dirty_out = t.drt;
        pmem_resp = t.presp;
    endtask

    task automatic checkOne(input string name, input int row, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s row %0d: got %0d expected %0d", name, row, actual, expected);
        end
    endtask

    task automatic checkOutput(input vec_t t, input int row);
        logic [9:0] act;
        logic [9:0] act_s;
        act   = {mem_resp, pmem_read, pmem_write, dirty_load, dirty_in,
                 valid_load, tag_load, data_load, data_in_sel, pmem_addr_sel};
        act_s = {s_mem_resp, s_pmem_read, s_pmem_write, s_dirty_load, s_dirty_in,
                 s_valid_load, s_tag_load, s_data_load, s_data_in_sel, s_pmem_addr_sel};
        total++;
        if (act !== t.ctrl) begin
            bad++;
            $display("[TB] FAIL ctrl row %0d: got %b expected %b", row, act, t.ctrl);
        end
        total++;
        if (act_s !== t.ctrl) begin
            bad++;
            $display("[TB] FAIL ctrl_sat row %0d: got %b expected %b", row, act_s, t.ctrl);
        end
        total++;
        if (pmem_read === 1'b1 && pmem_write === 1'b1) begin
            bad++;
            $display("[TB] FAIL pmem_excl row %0d: got rd=1 wr=1 expected not both", row);
        end
        checkOne("hit_count",      row, int'(hit_count),    t.hc);
        checkOne("miss_count",     row, int'(miss_count),   t.mc);
        checkOne("wb_count",       row, int'(wb_count),     t.wc);
        checkOne("hit_count_sat",  row, int'(s_hit_count),  sat3(t.hc));
        checkOne("miss_count_sat", row, int'(s_miss_count), sat3(t.mc));
        checkOne("wb_count_sat",   row, int'(s_wb_count),   sat3(t.wc));
    endtask

    task automatic runRow(input vec_t t, input int row);
        @(posedge clk);
        #1;
        applyStimulus(t);
        @(negedge clk);
        checkOutput(t, row);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        //             rst rd wr h  v  d  p  ctrl    hit miss wb
        // read hit
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, NONE,   0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, RESP,   0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, NONE,   1, 0, 0));
        // write hit
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, NONE,   1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, WHIT,   1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, NONE,   2, 0, 0));
        // read and write together behave as a write
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, NONE,   2, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, WHIT,   2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, NONE,   3, 0, 0));
        // clean read miss, pmem_resp on fifth ALLOCATE cycle
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, NONE,   3, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, NONE,   3, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, PRD,    3, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, PRD,    3, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, PRD,    3, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, PRD,    3, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, FILL,   3, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, RESP,   3, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, NONE,   4, 1, 0));
        // dirty write miss
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, NONE,   4, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, NONE,   4, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, WBUSY,  4, 2, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, WBUSY,  4, 2, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 1, WBDONE, 4, 2, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, PRD,    4, 2, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 1, FILL,   4, 2, 1));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, WHIT,   4, 2, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, NONE,   5, 2, 1));
        // request dropped in COMPARE: back to IDLE, nothing counted
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, NONE,   5, 2, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, NONE,   5, 2, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, NONE,   5, 2, 1));
        // valid-but-clean miss goes straight to ALLOCATE and finishes without the CPU
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, NONE,   5, 2, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, NONE,   5, 2, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, PRD,    5, 3, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, FILL,   5, 3, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, NONE,   5, 3, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, NONE,   5, 3, 1));

        // reset mid-WRITEBACK wins over pmem_resp, then reset wins over a hit count
        rst_seq.push_back(mk(0, 0, 1, 0, 1, 1, 0, NONE,   5, 3, 1));
        rst_seq.push_back(mk(0, 0, 1, 0, 1, 1, 0, NONE,   5, 3, 1));
        rst_seq.push_back(mk(0, 0, 1, 0, 1, 1, 0, WBUSY,  5, 4, 1));
        rst_seq.push_back(mk(1, 0, 1, 0, 1, 1, 1, WBDONE, 5, 4, 1));
        rst_seq.push_back(mk(0, 0, 0, 0, 1, 1, 0, NONE,   0, 0, 0));
        rst_seq.push_back(mk(0, 1, 0, 1, 0, 0, 0, NONE,   0, 0, 0));
        rst_seq.push_back(mk(1, 1, 0, 1, 0, 0, 0, RESP,   0, 0, 0));
        rst_seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, NONE,   0, 0, 0));
        rst_seq.push_back(mk(0, 1, 0, 1, 0, 0, 0, NONE,   0, 0, 0));
        rst_seq.push_back(mk(0, 1, 0, 1, 0, 0, 0, RESP,   0, 0, 0));
        rst_seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, NONE,   1, 0, 0));

        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        hit       = 1'b0;
        valid_out = 1'b0;
        dirty_out = 1'b0;
        pmem_resp = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            runRow(tbl[i], i);
        end
        for (int i = 0; i < rst_seq.size(); i++) begin
            runRow(rst_seq[i], 100 + i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
